int_sequencer: RTL and testbench

Multi-cycle controller that sequences the five-stage pipeline through hardware interrupt entry and RTI return. On an interrupt it stalls and flushes the front end, waits for in-flight instructions to retire, pushes the resume PC and CCR through the memory-stage stack port, then redirects fetch to the interrupt vector. On RTI it pops CCR and PC in reverse order and restores both. It sits beside the fetch stage and arbitrates the memory-stage push/pop path while active.

---
 rtl/int_sequencer_pkg.sv | 27 ++
 rtl/int_sequencer_edge_latch.sv | 33 +++
 rtl/int_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_int_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared definitions for the interrupt entry / RTI return sequencer:
// state encodings, default vector and drain length, and a small helper.
package int_sequencer_pkg;

  localparam logic [31:0] INT_VECTOR_DEFAULT   = 32'h0000_0000;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_I_DRAIN    = 4'd1,
    S_PUSH_PC_HI = 4'd2,
    S_PUSH_PC_LO = 4'd3,
    S_PUSH_CCR   = 4'd4,
    S_VECTOR     = 4'd5,
    S_R_DRAIN    = 4'd6,
    S_POP_CCR    = 4'd7,
    S_POP_PC_LO  = 4'd8,
    S_POP_PC_HI  = 4'd9,
    S_RESUME     = 4'd10
  } seq_state_t;

  // The drain counter counts down to zero, so a drain of N cycles starts at N-1.
  function automatic logic [3:0] drain_init(input int unsigned cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/int_sequencer_edge_latch.sv
// Rising-edge detector for the external interrupt line plus a sticky
// pending flag, so that an interrupt raised while the sequencer is busy
// is remembered and serviced once it returns to IDLE.
module int_edge_latch (
  input  logic clk,
  input  logic RESET,
  input  logic int_req,
  input  logic clear,
  output logic int_edge,
  output logic pending
);

  logic int_req_q;

  assign int_edge = int_req & ~int_req_q;

  // Track the previous line level; clear wins over a coincident edge because
  // clear means the sequencer is already starting service for that edge.
  always_ff @(posedge clk) begin
    if (RESET) begin
      int_req_q <= 1'b0;
      pending   <= 1'b0;
    end else begin
      int_req_q <= int_req;
      if (clear) begin
        pending <= 1'b0;
      end else if (int_edge) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt entry / RTI return sequencer. Stalls and flushes the front end,
// drains the pipeline, then pushes PC and CCR (entry) or pops them back
// (return) through the memory-stage stack port. All outputs are decoded
// from registered state only.
module int_sequencer
  import int_sequencer_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR   = INT_VECTOR_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        int_req,
  input  logic        rti_req,
  input  logic [31:0] resume_pc,
  input  logic [2:0]  ccr,
  input  logic        stack_ack,
  input  logic [15:0] pop_data,
  output logic        stall_fetch,
  output logic        flush_fd,
  output logic        push_req,
  output logic        pop_req,
  output logic [15:0] push_data,
  output logic        pc_load,
  output logic [31:0] pc_load_value,
  output logic        ccr_load,
  output logic [2:0]  ccr_restore,
  output logic        int_ack,
  output logic        busy
);

  localparam logic [3:0] DRAIN_INIT = drain_init(DRAIN_CYCLES);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [3:0]  drain_cnt;
  logic [31:0] saved_pc;
  logic [2:0]  saved_ccr;
  logic [2:0]  popped_ccr;
  logic [15:0] popped_lo;
  logic [15:0] popped_hi;
  logic        int_edge;
  logic        pending;
  logic        start_int;

  // RTI has priority in IDLE; a coincident edge is left pending by the latch.
  assign start_int = (state == S_IDLE) && !rti_req && (int_edge || pending);

  int_edge_latch u_edge_latch (
    .clk      (clk),
    .RESET    (RESET),
    .int_req  (int_req),
    .clear    (start_int),
    .int_edge (int_edge),
    .pending  (pending)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and Moore output decode.
  always_comb begin
    state_next    = state;
    stall_fetch   = 1'b0;
    flush_fd      = 1'b0;
    busy          = 1'b0;
    push_req      = 1'b0;
    pop_req       = 1'b0;
    push_data     = 16'h0000;
    pc_load       = 1'b0;
    pc_load_value = 32'h0000_0000;
    ccr_load      = 1'b0;
    ccr_restore   = 3'b000;
    int_ack       = 1'b0;

    if (state != S_IDLE) begin
      stall_fetch = 1'b1;
      flush_fd    = 1'b1;
      busy        = 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (rti_req) begin
          state_next = S_R_DRAIN;
        end else if (int_edge || pending) begin
          state_next = S_I_DRAIN;
        end
      end
      S_I_DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_next = S_PUSH_PC_HI;
        end
      end
      S_PUSH_PC_HI: begin
        push_req  = 1'b1;
        push_data = saved_pc[31:16];
        if (stack_ack) begin
          state_next = S_PUSH_PC_LO;
        end
      end
      S_PUSH_PC_LO: begin
        push_req  = 1'b1;
        push_data = saved_pc[15:0];
        if (stack_ack) begin
          state_next = S_PUSH_CCR;
        end
      end
      S_PUSH_CCR: begin
        push_req  = 1'b1;
        push_data = {13'b0, saved_ccr};
        if (stack_ack) begin
          state_next = S_VECTOR;
        end
      end
      S_VECTOR: begin
        pc_load       = 1'b1;
        pc_load_value = INT_VECTOR;
        int_ack       = 1'b1;
        state_next    = S_IDLE;
      end
      S_R_DRAIN: begin
        if (drain_cnt == 4'd0) begin
          state_next = S_POP_CCR;
        end
      end
      S_POP_CCR: begin
        pop_req = 1'b1;
        if (stack_ack) begin
          state_next = S_POP_PC_LO;
        end
      end
      S_POP_PC_LO: begin
        pop_req = 1'b1;
        if (stack_ack) begin
          state_next = S_POP_PC_HI;
        end
      end
      S_POP_PC_HI: begin
        pop_req = 1'b1;
        if (stack_ack) begin
          state_next = S_RESUME;
        end
      end
      S_RESUME: begin
        pc_load       = 1'b1;
        pc_load_value = {popped_hi, popped_lo};
        ccr_load      = 1'b1;
        ccr_restore   = popped_ccr;
        state_next    = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Drain counter: loaded when a sequence leaves IDLE, counts down while draining.
  always_ff @(posedge clk) begin
    if (RESET) begin
      drain_cnt <= 4'd0;
    end else if (state == S_IDLE && state_next != S_IDLE) begin
      drain_cnt <= DRAIN_INIT;
    end else if ((state == S_I_DRAIN || state == S_R_DRAIN) && drain_cnt != 4'd0) begin
      drain_cnt <= drain_cnt - 4'd1;
    end
  end

  // Context capture: resume PC/CCR at interrupt start, popped halves on each acked pop.
  always_ff @(posedge clk) begin
    if (RESET) begin
      saved_pc   <= 32'h0000_0000;
      saved_ccr  <= 3'b000;
      popped_ccr <= 3'b000;
      popped_lo  <= 16'h0000;
      popped_hi  <= 16'h0000;
    end else begin
      if (start_int) begin
        saved_pc  <= resume_pc;
        saved_ccr <= ccr;
      end
      if (stack_ack) begin
        case (state)
          S_POP_CCR:   popped_ccr <= pop_data[2:0];
          S_POP_PC_LO: popped_lo  <= pop_data;
          S_POP_PC_HI: popped_hi  <= pop_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: a table of per-cycle vectors for the
// basic entry/return flow, hand-written corner sequences, and a randomized
// run checked against a transaction-level model of stack traffic and latency.
module tb_int_sequencer;

  localparam int          D       = 3;
  localparam logic [31:0] INT_VEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        RESET;
  logic        int_req;
  logic        rti_req;
  logic [31:0] resume_pc;
  logic [2:0]  ccr;
  logic        stack_ack;
  logic [15:0] pop_data;
  logic        stall_fetch;
  logic        flush_fd;
  logic        push_req;
  logic        pop_req;
  logic [15:0] push_data;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        ccr_load;
  logic [2:0]  ccr_restore;
  logic        int_ack;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem[$];
  logic [31:0] ctx_pc[$];
  logic [2:0]  ctx_ccr[$];
  bit          ack_pat[0:63];

  typedef struct {
    logic        int_req;
    logic        rti_req;
    logic [15:0] pop_data;
    logic [57:0] want;
  } vec_t;

  vec_t vecs[17];

  int_sequencer #(.INT_VECTOR(INT_VEC), .DRAIN_CYCLES(D)) dut (
    .clk           (clk),
    .RESET         (RESET),
    .int_req       (int_req),
    .rti_req       (rti_req),
    .resume_pc     (resume_pc),
    .ccr           (ccr),
    .stack_ack     (stack_ack),
    .pop_data      (pop_data),
    .stall_fetch   (stall_fetch),
    .flush_fd      (flush_fd),
    .push_req      (push_req),
    .pop_req       (pop_req),
    .push_data     (push_data),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .ccr_load      (ccr_load),
    .ccr_restore   (ccr_restore),
    .int_ack       (int_ack),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [57:0] pack_obs(input logic b, input logic pu, input logic po,
                                           input logic [15:0] pd, input logic pl,
                                           input logic [31:0] pv, input logic cl,
                                           input logic [2:0] cv, input logic ia);
    return {b, b, b, pu, po, pd, pl, pv, cl, cv, ia};
  endfunction

  function automatic logic [57:0] obs_actual();
    return {busy, stall_fetch, flush_fd, push_req, pop_req, push_data,
            pc_load, pc_load_value, ccr_load, ccr_restore, int_ack};
  endfunction

  function automatic vec_t mk(input logic ir, input logic rr, input logic [15:0] pd,
                              input logic b, input logic pu, input logic po,
                              input logic [15:0] pdat, input logic pl, input logic [31:0] pv,
                              input logic cl, input logic [2:0] cv, input logic ia);
    vec_t v;
    v.int_req  = ir;
    v.rti_req  = rr;
    v.pop_data = pd;
    v.want     = pack_obs(b, pu, po, pdat, pl, pv, cl, cv, ia);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act === want) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Advance one clock; the stack memory model reacts to the request seen before the edge.
  task automatic step();
    logic pr, po, a;
    logic [15:0] pd, dummy;
    pr = push_req; po = pop_req; a = stack_ack; pd = push_data;
    @(posedge clk);
    #1;
    if (pr && a) mem.push_back(pd);
    if (po && a && mem.size() > 0) dummy = mem.pop_back();
  endtask

  task automatic do_reset();
    RESET = 1'b1; int_req = 1'b0; rti_req = 1'b0; stack_ack = 1'b0;
    pop_data = 16'h0; resume_pc = 32'h0; ccr = 3'b0;
    step(); step();
    RESET = 1'b0;
    mem.delete(); ctx_pc.delete(); ctx_ccr.delete();
  endtask

  // One entry or return sequence; timing and data derive from the ack pattern and context stack.
  task automatic applyStimulus(input bit is_rti, input logic [31:0] pc, input logic [2:0] c,
                               input string tag);
    int acc_s[3], acc_e[3];
    int t, done, kk;
    logic [31:0] exp_pc;
    logic [2:0]  exp_c;
    logic [15:0] pd;
    logic pu, po, pl, cl, ia, b;
    logic [31:0] pv;
    logic [2:0]  cv;
    exp_pc = INT_VEC; exp_c = 3'b0;
    if (is_rti) begin
      exp_pc = ctx_pc.pop_back();
      exp_c  = ctx_ccr.pop_back();
    end else begin
      ctx_pc.push_back(pc);
      ctx_ccr.push_back(c);
    end
    t = D + 1;
    for (int k = 0; k < 3; k++) begin
      acc_s[k] = t;
      while (!ack_pat[t]) t++;
      acc_e[k] = t;
      t++;
    end
    done = t;
    for (int cyc = 0; cyc <= done + 1; cyc++) begin
      kk = -1;
      for (int k = 0; k < 3; k++) if (cyc >= acc_s[k] && cyc <= acc_e[k]) kk = k;
      b  = (cyc >= 1) && (cyc <= done);
      pu = !is_rti && kk >= 0;
      po = is_rti && kk >= 0;
      pd = 16'h0;
      if (pu) pd = (kk == 0) ? pc[31:16] : (kk == 1) ? pc[15:0] : {13'b0, c};
      pl = (cyc == done);
      pv = pl ? (is_rti ? exp_pc : INT_VEC) : 32'h0;
      cl = is_rti && pl;
      cv = cl ? exp_c : 3'b0;
      ia = !is_rti && pl;
      checkOutput($sformatf("%s cyc%0d", tag, cyc), 64'(obs_actual()),
                  64'(pack_obs(b, pu, po, pd, pl, pv, cl, cv, ia)));
      int_req   = !is_rti && (cyc <= 1);
      rti_req   = is_rti && (cyc == 0);
      resume_pc = (cyc == 0) ? pc : $urandom;
      ccr       = (cyc == 0) ? c : 3'($urandom_range(0, 7));
      stack_ack = ack_pat[cyc];
      pop_data  = (mem.size() > 0) ? mem[mem.size()-1] : 16'hDEAD;
      step();
    end
  endtask

  // RTI with an interrupt edge at int_cyc: the interrupt must follow the return exactly once.
  task automatic seq_rti_int(input int int_cyc, input string tag);
    int rl_cyc = -1, ia_cyc = -1, ia_cnt = 0;
    logic b8 = 1'b1, b9 = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (ccr_load && rl_cyc < 0) rl_cyc = cyc;
      if (int_ack) begin ia_cnt++; ia_cyc = cyc; end
      if (cyc == 8) b8 = busy;
      if (cyc == 9) b9 = busy;
      rti_req = (cyc == 0); int_req = (cyc == int_cyc);
      stack_ack = 1'b1; pop_data = 16'h0;
      resume_pc = 32'hCAFE_0010; ccr = 3'b010;
      step();
    end
    checkOutput({tag, " restore cycle"}, 64'(rl_cyc), 64'(D + 4));
    checkOutput({tag, " idle gap"}, 64'(b8), 64'(0));
    checkOutput({tag, " entry drain"}, 64'(b9), 64'(1));
    checkOutput({tag, " int_ack cycle"}, 64'(ia_cyc), 64'(2 * D + 9));
    checkOutput({tag, " int_ack count"}, 64'(ia_cnt), 64'(1));
  endtask

  // Reset mid-pop: everything drops, no PC load, and the pending interrupt is forgotten.
  task automatic seq_reset_mid();
    int seen = 0;
    do_reset();
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc == 5) checkOutput("reset_mid in pop_pc_lo", 64'(pop_req), 64'(1));
      rti_req = (cyc == 0); int_req = (cyc == 2);
      stack_ack = 1'b1; pop_data = 16'h1111;
      RESET = (cyc == 5);
      step();
    end
    checkOutput("reset_mid outputs", 64'(obs_actual()), 64'(0));
    RESET = 1'b0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (pc_load || busy) seen++;
      step();
    end
    checkOutput("reset_mid no activity", 64'(seen), 64'(0));
  endtask

  initial begin
    do_reset();
    checkOutput("reset outputs", 64'(obs_actual()), 64'(0));

    // Per-cycle vectors: interrupt entry with resume_pc 0001_2345 / ccr 101, then RTI.
    vecs[0]  = mk(1, 0, 16'h0,    0, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[1]  = mk(1, 0, 16'h0,    1, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[2]  = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[3]  = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[4]  = mk(0, 0, 16'h0,    1, 1, 0, 16'h0001, 0, 32'h0,         0, 3'b0,   0);
    vecs[5]  = mk(0, 0, 16'h0,    1, 1, 0, 16'h2345, 0, 32'h0,         0, 3'b0,   0);
    vecs[6]  = mk(0, 0, 16'h0,    1, 1, 0, 16'h0005, 0, 32'h0,         0, 3'b0,   0);
    vecs[7]  = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    1, INT_VEC,       0, 3'b0,   1);
    vecs[8]  = mk(0, 1, 16'h0,    0, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[9]  = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[10] = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[11] = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[12] = mk(0, 0, 16'h0005, 1, 0, 1, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[13] = mk(0, 0, 16'h2345, 1, 0, 1, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[14] = mk(0, 0, 16'h0001, 1, 0, 1, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    vecs[15] = mk(0, 0, 16'h0,    1, 0, 0, 16'h0,    1, 32'h0001_2345, 1, 3'b101, 0);
    vecs[16] = mk(0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 32'h0,         0, 3'b0,   0);
    resume_pc = 32'h0001_2345; ccr = 3'b101; stack_ack = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checkOutput($sformatf("table vec%0d", i), 64'(obs_actual()), 64'(vecs[i].want));
      int_req  = vecs[i].int_req;
      rti_req  = vecs[i].rti_req;
      pop_data = vecs[i].pop_data;
      step();
    end

    // Ack withheld three cycles in PUSH_PC_LO, then a normal return.
    for (int i = 0; i < 64; i++) ack_pat[i] = 1'b1;
    ack_pat[5] = 1'b0; ack_pat[6] = 1'b0; ack_pat[7] = 1'b0;
    applyStimulus(1'b0, 32'h0001_2345, 3'b101, "ack_hold entry");
    for (int i = 0; i < 64; i++) ack_pat[i] = 1'b1;
    applyStimulus(1'b1, 32'h0, 3'b0, "ack_hold return");

    do_reset();
    seq_rti_int(3, "int_during_rti");
    do_reset();
    seq_rti_int(0, "rti_int_same_cycle");
    seq_reset_mid();

    // Randomized nested entries/returns with random ack back-pressure.
    do_reset();
    for (int op = 0; op < 16; op++) begin
      bit is_rti;
      for (int i = 0; i < 64; i++) ack_pat[i] = (i >= 40) || ($urandom_range(0, 3) != 0);
      is_rti = (ctx_pc.size() > 0) && (($urandom_range(0, 1) == 1) || ctx_pc.size() >= 4);
      applyStimulus(is_rti, $urandom, 3'($urandom_range(0, 7)), $sformatf("rand op%0d", op));
    end
    while (ctx_pc.size() > 0) begin
      for (int i = 0; i < 64; i++) ack_pat[i] = (i >= 40) || ($urandom_range(0, 3) != 0);
      applyStimulus(1'b1, 32'h0, 3'b0, "rand unwind");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
